// File: rtl/cpu_trace_ctrl_if.sv
// Control/trace bundle between the trace sequencer and its environment
// (CPU core, register-file debug port, command source and trace sink).
// The master side is the sequencer itself; the slave side is everything else.
interface cpu_trace_ctrl_if;
  // commands
  logic        cmd_run;
  logic        cmd_step;
  logic        cmd_halt;
  // CPU state and retirement gate
  logic [31:0] pc;
  logic [31:0] inst;
  logic        cpu_en;
  // register-file debug read port
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  // trace stream
  logic        trc_valid;
  logic        trc_ready;
  logic [31:0] trc_data;
  logic        trc_last;
  // status
  logic        busy;
  logic        done;
  logic [31:0] retired;

  modport master (
    input  cmd_run, cmd_step, cmd_halt, pc, inst, dbg_rdata, trc_ready,
    output cpu_en, dbg_raddr, trc_valid, trc_data, trc_last, busy, done, retired
  );

  modport slave (
    output cmd_run, cmd_step, cmd_halt, pc, inst, dbg_rdata, trc_ready,
    input  cpu_en, dbg_raddr, trc_valid, trc_data, trc_last, busy, done, retired
  );
endinterface

// File: rtl/cpu_trace_ctrl.sv
// Run/step/halt sequencer for the single-cycle CPU. Before every retired
// instruction it streams a snapshot (pc, inst, NREG registers) out on a
// valid/ready channel, then opens cpu_en for exactly one clock. It stops for
// good on two back-to-back all-zero instructions or when MAX_INSTR is hit.
module cpu_trace_ctrl #(
  parameter int NREG      = 32,
  parameter int MAX_INSTR = 0
) (
  input  logic             clk,
  input  logic             reset,
  cpu_trace_ctrl_if.master bus
);

  localparam int              IW       = $clog2(NREG + 2);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NREG + 1);
  localparam logic [31:0]     MAX_W    = 32'(MAX_INSTR);

  // SETTLE is the one-cycle gap after EXEC so the end check sees the
  // freshly retired pc/inst and the updated retire count.
  typedef enum logic [2:0] {
    S_IDLE,
    S_DUMP,
    S_EXEC,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic          run_mode_q;
  logic          halt_req_q;
  logic          nop_seen_q;
  logic [31:0]   retired_q;
  logic [31:0]   retired_d;
  logic          busy_w;
  logic          end_cond;

  assign busy_w    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign retired_d = (retired_q == '1) ? retired_q : retired_q + 32'd1;
  assign end_cond  = ((bus.inst == '0) && nop_seen_q) ||
                     ((MAX_INSTR != 0) && (retired_q == MAX_W));

  // Sequencer: command decode, snapshot word index, retire bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      run_mode_q <= 1'b0;
      halt_req_q <= 1'b0;
      nop_seen_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      // A halt request is remembered until the current instruction retires.
      if (bus.cmd_halt && busy_w) begin
        halt_req_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_run || bus.cmd_step) begin
            run_mode_q <= bus.cmd_run;
            idx_q      <= '0;
            state_q    <= end_cond ? S_DONE : S_DUMP;
          end
        end
        S_DUMP: begin
          // trc_valid is always high here, so ready alone is the handshake.
          if (bus.trc_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q <= S_EXEC;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        S_EXEC: begin
          retired_q  <= retired_d;
          nop_seen_q <= (bus.inst == '0);
          if (halt_req_q || !run_mode_q) begin
            state_q    <= S_IDLE;
            halt_req_q <= 1'b0;
          end else begin
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          idx_q   <= '0;
          state_q <= end_cond ? S_DONE : S_DUMP;
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are a pure decode of the registered state and word index; the
  // data word stays stable under stall because cpu_en is low while dumping.
  always_comb begin
    bus.cpu_en    = (state_q == S_EXEC);
    bus.trc_valid = (state_q == S_DUMP);
    bus.trc_last  = (state_q == S_DUMP) && (idx_q == LAST_IDX);
    bus.busy      = busy_w;
    bus.done      = (state_q == S_DONE);
    bus.dbg_raddr = '0;
    bus.trc_data  = '0;
    if (state_q == S_DUMP) begin
      if (idx_q == '0) begin
        bus.trc_data = bus.pc;
      end else if (idx_q == IW'(1)) begin
        bus.trc_data = bus.inst;
      end else begin
        bus.dbg_raddr = 5'(idx_q - IW'(2));
        bus.trc_data  = bus.dbg_rdata;
      end
    end
  end

  assign bus.retired = retired_q;

endmodule

// File: tb/tb_cpu_trace_ctrl.sv
// Bench for cpu_trace_ctrl: a tiny CPU/regfile model feeds two instances
// (unlimited and MAX_INSTR=3); a reference model predicts each snapshot.
module tb_cpu_trace_ctrl;
  localparam int          NREG = 32;
  localparam int          SNAP = NREG + 2;
  localparam logic [31:0] PC0  = 32'h0040_0000;
  localparam int          WAIT_LIMIT = 5000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cpu_trace_ctrl_if ifc0 ();
  cpu_trace_ctrl_if ifc1 ();

  cpu_trace_ctrl #(.NREG(NREG), .MAX_INSTR(0)) dut (
    .clk(clk), .reset(reset), .bus(ifc0.master)
  );
  cpu_trace_ctrl #(.NREG(NREG), .MAX_INSTR(3)) dut_lim (
    .clk(clk), .reset(reset), .bus(ifc1.master)
  );

  // ---------------- environment: CPU + regfile model ----------------
  logic [31:0] stream [16];
  logic [31:0] reg_seed;
  logic [31:0] k0, k1;
  int          sel;
  logic        c_run, c_step, c_halt, rdy;

  function automatic logic [31:0] regval(input logic [31:0] seed, input logic [31:0] k,
                                         input logic [4:0] r);
    return seed ^ (k * 32'h9E37_79B9) ^ ({27'd0, r} * 32'h0100_0193) ^ {r, 27'd0};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      k0 <= '0;
      k1 <= '0;
    end else begin
      if (ifc0.cpu_en) k0 <= k0 + 32'd1;
      if (ifc1.cpu_en) k1 <= k1 + 32'd1;
    end
  end

  assign ifc0.pc        = PC0 + (k0 << 2);
  assign ifc0.inst      = stream[k0[3:0]];
  assign ifc0.dbg_rdata = regval(reg_seed, k0, ifc0.dbg_raddr);
  assign ifc0.cmd_run   = (sel == 0) & c_run;
  assign ifc0.cmd_step  = (sel == 0) & c_step;
  assign ifc0.cmd_halt  = (sel == 0) & c_halt;
  assign ifc0.trc_ready = rdy;

  assign ifc1.pc        = PC0 + (k1 << 2);
  assign ifc1.inst      = stream[k1[3:0]];
  assign ifc1.dbg_rdata = regval(reg_seed, k1, ifc1.dbg_raddr);
  assign ifc1.cmd_run   = (sel == 1) & c_run;
  assign ifc1.cmd_step  = (sel == 1) & c_step;
  assign ifc1.cmd_halt  = (sel == 1) & c_halt;
  assign ifc1.trc_ready = rdy;

  logic        o_valid, o_last, o_en, o_busy, o_done;
  logic [31:0] o_data, o_ret;
  logic [4:0]  o_raddr;
  always_comb begin
    if (sel == 0) begin
      o_valid = ifc0.trc_valid; o_last = ifc0.trc_last; o_en = ifc0.cpu_en;
      o_busy = ifc0.busy; o_done = ifc0.done; o_data = ifc0.trc_data;
      o_ret = ifc0.retired; o_raddr = ifc0.dbg_raddr;
    end else begin
      o_valid = ifc1.trc_valid; o_last = ifc1.trc_last; o_en = ifc1.cpu_en;
      o_busy = ifc1.busy; o_done = ifc1.done; o_data = ifc1.trc_data;
      o_ret = ifc1.retired; o_raddr = ifc1.dbg_raddr;
    end
  end

  // ---------------- checking state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] got_d[$];
  bit          got_l[$];
  int          en_cnt, pat_i, rmode, halt_word;
  bit          halt_fired, stalled, held_last;
  logic [31:0] held_data;

  // reference model: instruction-level view of the sequencer
  int m_k, m_ret, m_max;
  bit m_nop, m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model(input bit is_run, input int halt_snap);
    int n;
    n = 0;
    if (m_done) return 0;
    forever begin
      if ((stream[m_k % 16] == 0 && m_nop) || (m_max != 0 && m_ret == m_max)) begin
        m_done = 1'b1;
        break;
      end
      n++;
      m_nop = (stream[m_k % 16] == 0);
      m_k++;
      m_ret++;
      if (!is_run || n == halt_snap) break;
    end
    return n;
  endfunction

  // One clock: observe at the falling edge, choose ready, log handshakes.
  task automatic tick();
    @(negedge clk);
    c_run = 1'b0; c_step = 1'b0; c_halt = 1'b0;
    if (stalled) begin
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_data", o_data, held_data);
      chk("stall_last", 32'(o_last), 32'(held_last));
    end
    if (o_en) begin
      en_cnt++;
      chk("en_without_valid", 32'(o_valid), 32'd0);
    end
    case (rmode)
      0:       rdy = 1'b1;
      1:       rdy = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
      default: rdy = 1'($urandom_range(0, 1));
    endcase
    pat_i++;
    if (o_valid && rdy) begin
      got_d.push_back(o_data);
      got_l.push_back(o_last);
      stalled = 1'b0;
    end else begin
      stalled   = o_valid;
      held_data = o_data;
      held_last = o_last;
    end
    if (!halt_fired && halt_word >= 0 && got_d.size() >= halt_word) begin
      c_halt     = 1'b1;
      halt_fired = 1'b1;
    end
  endtask

  task automatic apply_reset(input int new_sel);
    @(negedge clk);
    reset = 1'b1; c_run = 1'b0; c_step = 1'b0; c_halt = 1'b0; rdy = 1'b0;
    sel = new_sel;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_cpu_en", 32'(o_en), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_raddr", 32'(o_raddr), 32'd0);
    chk("rst_retired", o_ret, 32'd0);
    reset = 1'b0;
    stalled = 1'b0;
    m_k = 0; m_ret = 0; m_nop = 1'b0; m_done = 1'b0;
    m_max = (new_sel == 1) ? 3 : 0;
  endtask

  task automatic start_cmd(input bit is_run, input int hw);
    got_d.delete(); got_l.delete();
    en_cnt = 0; pat_i = 0; halt_word = hw; halt_fired = 1'b0;
    c_run = is_run; c_step = !is_run;
    tick();
  endtask

  task automatic finish_cmd();
    int n;
    n = 0;
    while (o_busy && n < WAIT_LIMIT) begin
      tick();
      n++;
    end
    chk("finish_in_time", 32'(o_busy), 32'd0);
  endtask

  task automatic compare(input int n, input int ks);
    int cnt;
    chk("word_count", 32'(got_d.size()), 32'(n * SNAP));
    cnt = (got_d.size() < n * SNAP) ? got_d.size() : n * SNAP;
    for (int i = 0; i < cnt; i++) begin
      int k;
      int w;
      logic [31:0] e;
      k = ks + i / SNAP;
      w = i % SNAP;
      if (w == 0)      e = PC0 + 32'(4 * k);
      else if (w == 1) e = stream[k % 16];
      else             e = regval(reg_seed, 32'(k), 5'(w - 2));
      chk($sformatf("word%0d", i), got_d[i], e);
      chk($sformatf("last%0d", i), 32'(got_l[i]), 32'(w == SNAP - 1));
    end
    chk("cpu_en_pulses", 32'(en_cnt), 32'(n));
    chk("retired", o_ret, 32'(m_ret));
    chk("done", 32'(o_done), 32'(m_done));
  endtask

  task automatic run_and_check(input string name, input bit is_run, input int hw,
                               input int halt_snap);
    int ks;
    int n;
    ks = m_k;
    n  = model(is_run, halt_snap);
    start_cmd(is_run, hw);
    finish_cmd();
    compare(n, ks);
    $display("%s: %s words=%0d cpu_en=%0d retired=%0d done=%0b", name,
             is_run ? "run" : "step", got_d.size(), en_cnt, o_ret, o_done);
  endtask

  initial begin
    c_run = 1'b0; c_step = 1'b0; c_halt = 1'b0; rdy = 1'b0;
    sel = 0; rmode = 0; halt_word = -1; stalled = 1'b0;
    reg_seed = $urandom;
    for (int i = 0; i < 16; i++) stream[i] = $urandom | 32'h1;

    // T1: single step from reset
    stream[0] = 32'h2001_0005;
    apply_reset(0);
    rmode = 0;
    run_and_check("T1", 1'b0, -1, -1);

    // T2: step under 1,0,0,1 backpressure
    apply_reset(0);
    rmode = 1;
    run_and_check("T2", 1'b0, -1, -1);

    // T3: run until two consecutive nops, then a late run does nothing
    apply_reset(0);
    stream[0] = $urandom | 32'h1; stream[1] = $urandom | 32'h1;
    stream[2] = 32'd0; stream[3] = 32'd0;
    rmode = 2;
    run_and_check("T3", 1'b1, -1, -1);
    run_and_check("T3b", 1'b1, -1, -1);

    // T4: halt during snapshot 2, then one more step
    apply_reset(0);
    for (int i = 0; i < 16; i++) stream[i] = $urandom | 32'h1;
    rmode = 2;
    run_and_check("T4", 1'b1, SNAP + 10, 2);
    run_and_check("T4b", 1'b0, -1, -1);

    // T5: retire limit of 3 on the limited instance
    apply_reset(1);
    rmode = 2;
    run_and_check("T5", 1'b1, -1, -1);
    run_and_check("T5b", 1'b0, -1, -1);

    // T6: reset in the middle of a snapshot
    apply_reset(0);
    rmode = 0;
    start_cmd(1'b0, -1);
    begin
      int w;
      w = 0;
      while (got_d.size() < 20 && w < WAIT_LIMIT) begin
        tick();
        w++;
      end
      chk("t6_reach_word20", 32'(got_d.size() >= 20), 32'd1);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("t6_valid", 32'(o_valid), 32'd0);
    chk("t6_cpu_en", 32'(o_en), 32'd0);
    chk("t6_retired", o_ret, 32'd0);
    chk("t6_busy", 32'(o_busy), 32'd0);
    chk("t6_data", o_data, 32'd0);
    reset = 1'b0;
    stalled = 1'b0;
    m_k = 0; m_ret = 0; m_nop = 1'b0; m_done = 1'b0; m_max = 0;
    run_and_check("T6", 1'b0, -1, -1);

    // Random streams with sprinkled nops: a step, then a free run
    for (int it = 0; it < 3; it++) begin
      apply_reset(0);
      for (int i = 0; i < 16; i++)
        stream[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom | 32'h1);
      stream[14] = 32'd0;
      stream[15] = 32'd0;
      rmode = 2;
      run_and_check($sformatf("R%0d", it), 1'b0, -1, -1);
      run_and_check($sformatf("R%0d", it), 1'b1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
